// File: rtl/kij_pass_sequencer.sv
// kij_pass_sequencer: drives the 37-bit core inst word for one kernel-offset pass
// (weights -> L0 -> PE, settle gap, activations -> L0, execute, OFIFO -> pmem).
module kij_pass_sequencer #(
   parameter int unsigned COL     = 8,
   parameter int unsigned ROW     = 8,
   parameter int unsigned LEN_NIJ = 64,
   parameter int unsigned GAP     = 10,
   parameter int unsigned NKIJ    = 9,
   parameter int unsigned W_BASE  = 1024,
   parameter int unsigned P_BASE  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  kij,
   input  logic        ofifo_valid,
   output logic [36:0] inst,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned AW      = 11;
   localparam int unsigned CNT_MAX = (COL + 1 > GAP)
                                     ? ((COL + 1 > LEN_NIJ + 1) ? COL + 1 : LEN_NIJ + 1)
                                     : ((GAP > LEN_NIJ + 1) ? GAP : LEN_NIJ + 1);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned DCNT_W  = $clog2(LEN_NIJ + 1);

   // inst word field positions
   localparam int unsigned B_L0RM  = 36;
   localparam int unsigned B_MODE  = 35;
   localparam int unsigned B_DMODE = 34;
   localparam int unsigned B_CENP  = 32;
   localparam int unsigned B_WENP  = 31;
   localparam int unsigned A_P_LSB = 20;
   localparam int unsigned B_CENX  = 19;
   localparam int unsigned A_X_LSB = 7;
   localparam int unsigned B_OFRD  = 6;
   localparam int unsigned B_L0RD  = 3;
   localparam int unsigned B_L0WR  = 2;
   localparam int unsigned B_EXEC  = 1;
   localparam int unsigned B_LOAD  = 0;

   localparam logic [36:0] IDLE_WORD = 37'h1_800C_0000;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WLD   = 3'd1;
   localparam logic [2:0] S_KLOAD = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_ALD   = 3'd4;
   localparam logic [2:0] S_EXEC  = 3'd5;
   localparam logic [2:0] S_DRAIN = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   // Reject parameter sets the counters and kij port cannot represent
   if (COL < 1 || ROW < 1 || LEN_NIJ < 1 || GAP < 1 || NKIJ < 1 || NKIJ > 16) begin : g_bad_param
      $error("kij_pass_sequencer: illegal parameter set");
   end

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DCNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [DCNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [3:0]        kij_q, kij_d;
   logic              err_d, rd_d, wr_d;
   logic [36:0]       inst_d;

   // Next state, phase counter and DRAIN read/write bookkeeping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      kij_d   = kij_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (32'(kij) < NKIJ) begin
                  state_d = S_WLD;
                  kij_d   = kij;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WLD:   if (cnt_q == CNT_W'(COL))         begin state_d = S_KLOAD; cnt_d = '0; end
         S_KLOAD: if (cnt_q == CNT_W'(COL - 1))     begin state_d = S_GAP;   cnt_d = '0; end
         S_GAP:   if (cnt_q == CNT_W'(GAP - 1))     begin state_d = S_ALD;   cnt_d = '0; end
         S_ALD:   if (cnt_q == CNT_W'(LEN_NIJ))     begin state_d = S_EXEC;  cnt_d = '0; end
         S_EXEC:  if (cnt_q == CNT_W'(LEN_NIJ - 1)) begin state_d = S_DRAIN; cnt_d = '0; end
         S_DRAIN: begin
            cnt_d = '0;
            if (wr_cnt_q == DCNT_W'(LEN_NIJ)) state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A read is issued on the sampled valid; its pmem write follows one cycle later
      rd_d     = (state_d == S_DRAIN) && ofifo_valid && (rd_cnt_q < DCNT_W'(LEN_NIJ));
      wr_d     = (state_q == S_DRAIN) && (state_d == S_DRAIN) && inst[B_OFRD];
      rd_cnt_d = (state_d == S_DRAIN) ? rd_cnt_q + DCNT_W'(rd_d) : '0;
      wr_cnt_d = (state_d == S_DRAIN) ? wr_cnt_q + DCNT_W'(wr_d) : '0;
   end

   // Instruction word for the cycle being entered
   always_comb begin
      inst_d = IDLE_WORD;
      case (state_d)
         S_WLD: begin
            inst_d[B_MODE]  = 1'b1;
            inst_d[B_DMODE] = 1'b1;
            if (cnt_d < CNT_W'(COL)) begin
               inst_d[B_CENX]          = 1'b0;
               inst_d[A_X_LSB +: AW]   = AW'(W_BASE + 32'(kij_d) * COL + 32'(cnt_d));
            end
            if (cnt_d != '0) inst_d[B_L0WR] = 1'b1;
         end
         S_KLOAD: begin
            inst_d[B_L0RM] = 1'b1;
            inst_d[B_MODE] = 1'b1;
            inst_d[B_L0RD] = 1'b1;
            inst_d[B_LOAD] = 1'b1;
         end
         S_ALD: begin
            inst_d[B_MODE] = 1'b1;
            if (cnt_d < CNT_W'(LEN_NIJ)) begin
               inst_d[B_CENX]        = 1'b0;
               inst_d[A_X_LSB +: AW] = AW'(cnt_d);
            end
            if (cnt_d != '0) inst_d[B_L0WR] = 1'b1;
         end
         S_EXEC: begin
            inst_d[B_MODE] = 1'b1;
            inst_d[B_L0RD] = 1'b1;
            inst_d[B_EXEC] = 1'b1;
         end
         S_DRAIN: begin
            inst_d[B_OFRD] = rd_d;
            if (wr_d) begin
               inst_d[B_CENP]        = 1'b0;
               inst_d[B_WENP]        = 1'b0;
               inst_d[A_P_LSB +: AW] = AW'(P_BASE + 32'(kij_q) * LEN_NIJ + 32'(wr_cnt_q));
            end
         end
         default: ;
      endcase
   end

   // State and registered outputs; reset aborts any pass in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         kij_q    <= '0;
         inst     <= IDLE_WORD;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         kij_q    <= kij_d;
         inst     <= inst_d;
         busy     <= (state_d != S_IDLE);
         done     <= (state_d == S_DONE);
         err      <= err_d;
      end
   end

endmodule

// File: tb/tb_kij_pass_sequencer.sv
// Bench for kij_pass_sequencer: per-cycle comparison against a pass-level reference model.
module tb_kij_pass_sequencer;

   localparam int COL  = 8;
   localparam int LEN  = 64;
   localparam int GAPC = 10;
   localparam int WB   = 1024;
   localparam int PB   = 0;
   localparam int D0   = (COL + 1) + COL + GAPC + (LEN + 1) + LEN;
   localparam int MAXC = 2500;
   localparam logic [36:0] IDLE_W = 37'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset, start, ofifo_valid;
   logic [3:0]  kij;
   logic [36:0] inst;
   logic        busy, done, err;

   int          n_vec = 0;
   int          n_bad = 0;
   bit          vpat [MAXC];
   logic [36:0] e_inst [$];
   int          done_c;

   kij_pass_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .kij         (kij),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Single comparison point
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [36:0] word(bit l0rm, bit md, bit dm, bit cenp, bit wenp,
                                        logic [10:0] ap, bit cenx, bit wenx, logic [10:0] ax,
                                        bit ofrd, bit l0rd, bit l0wr, bit exe, bit ld);
      return {l0rm, md, dm, 1'b0, cenp, wenp, ap, cenx, wenx, ax,
              ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
   endfunction

   // Expected inst sequence for one pass, given kij and the ofifo_valid pattern
   task automatic build_model(input int k, input int mode);
      int  reads, writes, c;
      bit  rd, prev_rd;
      e_inst.delete();
      for (int i = 0; i < MAXC; i++) begin
         if (i < D0 - 1)      vpat[i] = bit'($urandom_range(0, 1));
         else if (i >= 1500)  vpat[i] = 1'b1;
         else if (mode == 0)  vpat[i] = 1'b1;
         else if (mode == 1)  vpat[i] = ((i - (D0 - 1)) % 2 == 0);
         else if (mode == 2)  vpat[i] = ($urandom_range(0, 2) != 0);
         else                 vpat[i] = ($urandom_range(0, 3) == 0);
      end
      for (int j = 0; j <= COL; j++)
         e_inst.push_back(word(0, 1, 1, 1, 1, 11'd0, (j >= COL), 1,
                               (j < COL) ? 11'(WB + k * COL + j) : 11'd0, 0, 0, (j >= 1), 0, 0));
      for (int j = 0; j < COL; j++)
         e_inst.push_back(word(1, 1, 0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 0, 1));
      for (int j = 0; j < GAPC; j++) e_inst.push_back(IDLE_W);
      for (int j = 0; j <= LEN; j++)
         e_inst.push_back(word(0, 1, 0, 1, 1, 11'd0, (j >= LEN), 1,
                               (j < LEN) ? 11'(j) : 11'd0, 0, 0, (j >= 1), 0, 0));
      for (int j = 0; j < LEN; j++)
         e_inst.push_back(word(0, 1, 0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 1, 0));
      reads = 0; writes = 0; prev_rd = 0; c = D0;
      while (c < MAXC - 2) begin
         rd = vpat[c - 1] && (reads < LEN);
         if (prev_rd)
            e_inst.push_back(word(0, 0, 0, 0, 0, 11'(PB + k * LEN + writes), 1, 1, 11'd0, rd, 0, 0, 0, 0));
         else
            e_inst.push_back(word(0, 0, 0, 1, 1, 11'd0, 1, 1, 11'd0, rd, 0, 0, 0, 0));
         if (prev_rd) writes++;
         if (rd) reads++;
         prev_rd = rd;
         if (writes == LEN) break;
         c++;
      end
      done_c = c + 1;
      e_inst.push_back(IDLE_W);
   endtask

   // Launch a pass from IDLE and compare every cycle; optional reset abort and stray starts
   task automatic run_pass(input int k, input int mode, input int abort_at, input bit strays);
      build_model(k, mode);
      start = 1'b1;
      kij   = 4'(k);
      for (int c = 0; c <= done_c + 1; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (strays && c < done_c && $urandom_range(0, 7) == 0) begin
            start = 1'b1;
            kij   = 4'($urandom_range(0, 15));
         end
         ofifo_valid = vpat[c];
         if (c == abort_at) reset = 1'b1;
         @(negedge clk);
         if (c <= done_c) begin
            chk("inst", 64'(inst), 64'(e_inst[c]));
            chk("busy", 64'(busy), 64'(1));
            chk("done", 64'(done), 64'(c == done_c));
         end else begin
            chk("post_inst", 64'(inst), 64'(IDLE_W));
            chk("post_busy", 64'(busy), 64'(0));
            chk("post_done", 64'(done), 64'(0));
         end
         chk("err", 64'(err), 64'(0));
         if (c == abort_at) begin
            start = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("abort_inst", 64'(inst), 64'(IDLE_W));
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_done", 64'(done), 64'(0));
            return;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; kij = 4'd0; ofifo_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_inst", 64'(inst), 64'(IDLE_W));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err",  64'(err),  64'(0));
      reset = 1'b0;

      // Illegal kij: err pulse only, no pass
      for (int i = 0; i < 4; i++) begin
         start = 1'b1;
         kij   = (i == 0) ? 4'd9 : 4'($urandom_range(9, 15));
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         chk("err_pulse", 64'(err),  64'(1));
         chk("err_busy",  64'(busy), 64'(0));
         chk("err_inst",  64'(inst), 64'(IDLE_W));
         @(negedge clk);
         chk("err_clear", 64'(err),  64'(0));
         chk("err_busy2", 64'(busy), 64'(0));
      end

      run_pass(2, 0, -1, 1'b0);
      run_pass(2, 1, -1, 1'b0);
      run_pass($urandom_range(0, 8), 0, D0 - LEN + 30, 1'b0);
      run_pass(2, 0, -1, 1'b1);
      run_pass(8, 2, -1, 1'b1);
      run_pass(0, 3, -1, 1'b1);
      for (int i = 0; i < 3; i++)
         run_pass($urandom_range(0, 8), $urandom_range(0, 3), -1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
